mem_responder: RTL and testbench

//  Word-addressed data-memory responder on the load/store side of the datapath.

---
 rtl/mem_responder.sv | 160 ++++++++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : Word-addressed data-memory responder with a valid/ready
//               request handshake and a fixed number of wait states before
//               each one-cycle response. Misaligned and out-of-range accesses
//               return an error and never touch the array.
//               Optional macro MEM_BYTE_EN adds byte loads/stores (req_byte).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int ADDR_BITS   = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
`ifdef MEM_BYTE_EN
  input  logic        req_byte,
`endif
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int         c_depth     = 1 << ADDR_BITS;
  localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_count;
  logic [3:0]      w_count_next;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic            r_we;
  logic [31:0]     r_mem [c_depth];

  logic            w_accept;
  logic            w_commit;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic            w_we;
  logic [ADDR_BITS-1:0] w_idx;
  logic            w_err;
  logic [31:0]     w_word;
  logic [31:0]     w_rdata;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  // No transfer may start while reset is held low.
  assign w_accept   = req_valid && req_ready && reset;

  // With zero wait states the commit happens on the accept edge, so the
  // live request is used in IDLE and the latched one afterwards.
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_idx   = w_addr[ADDR_BITS+1:2];
  assign w_word  = r_mem[w_idx];

`ifdef MEM_BYTE_EN
  logic r_byte;
  logic w_byte;
  assign w_byte  = (r_state == S_IDLE) ? req_byte : r_byte;
  // Byte accesses skip alignment; the range check always applies.
  assign w_err   = (w_addr[31:ADDR_BITS+2] != '0) || (!w_byte && (w_addr[1:0] != 2'b00));
  assign w_rdata = w_byte ? {24'd0, w_word[{w_addr[1:0], 3'b000} +: 8]} : w_word;
`else
  assign w_err   = (w_addr[31:ADDR_BITS+2] != '0) || (w_addr[1:0] != 2'b00);
  assign w_rdata = w_word;
`endif

  // Next-state logic: IDLE -> WAIT (count down) -> RESP -> IDLE.
  always_comb begin
    w_next       = r_state;
    w_count_next = r_count;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_next   = S_RESP;
            w_commit = 1'b1;
          end else begin
            w_next       = S_WAIT;
            w_count_next = c_wait_init;
          end
        end
      end
      S_WAIT: begin
        if (r_count == 4'd0) begin
          w_next   = S_RESP;
          w_commit = 1'b1;
        end else begin
          w_count_next = r_count - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, request latch and response registers; response holds until next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
`ifdef MEM_BYTE_EN
      r_byte     <= 1'b0;
`endif
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_count <= w_count_next;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_we    <= req_we;
`ifdef MEM_BYTE_EN
        r_byte  <= req_byte;
`endif
      end
      if (w_commit) begin
        resp_err   <= w_err;
        resp_rdata <= (w_err || w_we) ? 32'd0 : w_rdata;
      end
    end
  end

  // Array write at the commit edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_we && !w_err) begin
`ifdef MEM_BYTE_EN
      if (w_byte) begin
        r_mem[w_idx][{w_addr[1:0], 3'b000} +: 8] <= w_wdata[7:0];
      end else begin
        r_mem[w_idx] <= w_wdata;
      end
`else
      r_mem[w_idx] <= w_wdata;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Scoreboard bench for mem_responder. The driver pushes the
//               expected response at each accepted request; a monitor pops
//               and compares whenever resp_valid is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  localparam int ADDR_BITS   = 6;
  localparam int WAIT_CYCLES = 2;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
`ifdef MEM_BYTE_EN
  logic        req_byte  = 1'b0;
`endif

  int cyc    = 0;
  int errors = 0;
  int checks = 0;
  int prev_h = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          h;
  } exp_t;

  exp_t q[$];

  mem_responder #(
    .ADDR_BITS   (ADDR_BITS),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
`ifdef MEM_BYTE_EN
    .req_byte   (req_byte),
`endif
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  // Free-running clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request and hold it until the handshake; leaves req_valid high.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit track, input bit gap);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    do begin
      @(negedge clk);
      t++;
    end while (!req_ready && t < 64);
    if (!req_ready) begin
      errors++;
      checks++;
      $display("FAIL accept_timeout: addr 0x%08h not accepted within %0d cycles", addr, t);
      req_valid = 1'b0;
      return;
    end
    if (gap) check("accept_gap", cyc - prev_h, WAIT_CYCLES + 2);
    prev_h = cyc;
    if (track) q.push_back('{exp_rd, exp_err, cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      if (q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_resp: resp_valid with no request outstanding (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_latency", cyc - e.h, WAIT_CYCLES + 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_req_ready",  {31'd0, req_ready},  32'd1);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_resp_rdata", resp_rdata,          32'd0);
    check("reset_resp_err",   {31'd0, resp_err},   32'd0);
    @(posedge clk);
    #1;

    // Store then load back.
    issue(1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
    idle();
    drain();

    // Errors never modify or alias into the array.
    issue(1'b1, 32'h00,       32'h55AA1234, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h12,       32'h0,        32'h0,        1'b1, 1'b1, 1'b0);
    issue(1'b0, 32'h100,      32'h0,        32'h0,        1'b1, 1'b1, 1'b0);
    issue(1'b1, 32'h100,      32'h0BADBAD0, 32'h0,        1'b1, 1'b1, 1'b0);
    issue(1'b1, 32'h01,       32'hFFFFFFFF, 32'h0,        1'b1, 1'b1, 1'b0);
    issue(1'b0, 32'h80000000, 32'h0,        32'h0,        1'b1, 1'b1, 1'b0);
    issue(1'b0, 32'h00,       32'h0,        32'h55AA1234, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'hFC,       32'hA5A55A5A, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'hFC,       32'h0,        32'hA5A55A5A, 1'b0, 1'b1, 1'b0);
    idle();
    drain();

    // Continuous req_valid: one accept every WAIT_CYCLES+2 cycles.
    issue(1'b1, 32'h40, 32'h11111111, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h44, 32'h22222222, 32'h0,        1'b0, 1'b1, 1'b1);
    issue(1'b0, 32'h40, 32'h0,        32'h11111111, 1'b0, 1'b1, 1'b1);
    issue(1'b0, 32'h44, 32'h0,        32'h22222222, 1'b0, 1'b1, 1'b1);
    idle();
    drain();

    // Reset mid-WAIT drops a pending store and clears outputs immediately.
    issue(1'b1, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    idle();
    drain();
    issue(1'b1, 32'h20, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0);
    idle();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("async_rst_resp_rdata", resp_rdata,          32'd0);
    check("async_rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("async_rst_req_ready",  {31'd0, req_ready},  32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    issue(1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
    idle();
    drain();

`ifdef MEM_BYTE_EN
    // Byte lanes are little-endian; byte loads zero-extend.
    issue(1'b1, 32'h04, 32'h00000000, 32'h0, 1'b0, 1'b1, 1'b0);
    req_byte = 1'b1;
    issue(1'b1, 32'h06, 32'h000000AB, 32'h0, 1'b0, 1'b1, 1'b0);
    req_byte = 1'b0;
    issue(1'b0, 32'h04, 32'h0, 32'h00AB0000, 1'b0, 1'b1, 1'b0);
    req_byte = 1'b1;
    issue(1'b0, 32'h06, 32'h0, 32'h000000AB, 1'b0, 1'b1, 1'b0);
    issue(1'b0, 32'h106, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    req_byte = 1'b0;
    idle();
    drain();
`endif

    check("responses_outstanding", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
